divider_unsigned: RTL

Sequential unsigned restoring divider, the inverse of the shift-add multiplier in the arithmetic unit. It accepts a dividend and divisor on a start strobe and produces one quotient bit per clock. It returns quotient and remainder with a ready flag. It sits beside the multiplier on the ALU result mux and serves DIV/MOD instructions; the control unit stalls on `busy`.

---
 rtl/alu_pkg.sv | 13 +
 rtl/add.sv | 12 +
 rtl/divider_step.sv | 29 ++
 rtl/divider_unsigned.sv | 87 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding, default width,
// and the quotient returned for a zero divisor.
package alu_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/add.sv
// Ripple-style W-bit adder with carry in/out, shared by the ALU datapaths.
module add #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c_in};
endmodule

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when no borrow occurs.
module divider_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       no_borrow;

  assign shifted = {rem_in[W-1:0], q_msb};

  add #(.W(W+1)) u_sub (
    .x     (shifted),
    .y     (~{1'b0, divisor}),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (no_borrow)
  );

  // A set top bit would make the shifted value exceed any divisor.
  assign q_bit   = no_borrow | rem_in[W];
  assign rem_out = q_bit ? diff : shifted;
endmodule

// File: rtl/divider_unsigned.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// WIDTH steps per operation, zero divisor short-circuits straight to DONE.
module divider_unsigned
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;

  divider_step #(.W(WIDTH)) u_step (
    .rem_in  (rem),
    .q_msb   (q[WIDTH-1]),
    .divisor (d),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      rem         <= '0;
      count       <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            d     <= b;
            count <= '0;
            if (b == '0) begin
              q           <= WIDTH'(DIV0_QUOTIENT);
              rem         <= {1'b0, a};
              div_by_zero <= 1'b1;
              state       <= DONE;
              ready       <= 1'b1;
              busy        <= 1'b0;
            end else begin
              q           <= a;
              rem         <= '0;
              div_by_zero <= 1'b0;
              state       <= RUN;
              ready       <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        RUN: begin
          rem   <= rem_nxt;
          q     <= {q[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign quotient  = q;
  assign remainder = rem[WIDTH-1:0];
endmodule
